// File: rtl/a5_1_keystream_ctrl.sv
// a5_1_keystream_ctrl
// Sequencer for the three A5/1 LFSRs (X 19b, Y 22b, Z 23b): issues the key
// load strobe, runs the majority-clocked warm-up, then packs the keystream
// (XOR of the three MSBs) MSB-first into bytes and hands them out over a
// valid/ready stream. Stepping stalls under back-pressure so no bit is lost.
// Optional build macro: A51_FORCE_STEP_EN adds input force_step which, while
// high on a step cycle, forces all three trig outputs high.
module a5_1_keystream_ctrl #(
  parameter int WARMUP_STEPS = 100,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_bytes,
  input  logic             abort,
  output logic             ld_key,
  output logic             x_trig,
  output logic             y_trig,
  output logic             z_trig,
  input  logic             x_maj,
  input  logic             y_maj,
  input  logic             z_maj,
  input  logic             x_out,
  input  logic             y_out,
  input  logic             z_out,
  output logic [7:0]       ks_data,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic             busy,
  output logic             done
`ifdef A51_FORCE_STEP_EN
  ,
  input  logic             force_step
`endif
);

  localparam int WARM_W = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WARM  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  // Majority of the three clocking bits.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Keystream bit: parity of the three register MSBs.
  function automatic logic ks_bit(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;       // requested byte count
  logic [CNT_W-1:0] prod_q, prod_d;     // bytes fully assembled
  logic [CNT_W-1:0] acpt_q, acpt_d;     // bytes accepted by the consumer
  logic [WARM_W-1:0] warm_q, warm_d;    // warm-up step counter
  logic             step_en_q, step_en_d;
  logic [7:0]       acc_q, acc_d;       // bit accumulator, newest bit in [0]
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;     // output byte register
  logic             valid_q, valid_d;
  logic             ld_key_q, ld_key_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic maj_s;
  logic hs_s;
  logic out_free_s;
  logic acc_full_s;
  logic stall_s;
  logic step_s;
  logic capture_s;
  logic force_s;
  logic bit_s;
  logic [7:0] shifted_s;
  logic byte_done_s;
  logic [CNT_W-1:0] prod_inc_s;
  logic [CNT_W-1:0] acpt_inc_s;

`ifdef A51_FORCE_STEP_EN
  assign force_s = force_step;
`else
  assign force_s = 1'b0;
`endif

  // Step qualification: a step happens when enabled and not back-pressured.
  always_comb begin
    maj_s      = maj3(x_maj, y_maj, z_maj);
    bit_s      = ks_bit(x_out, y_out, z_out);
    hs_s       = valid_q & ks_ready;
    out_free_s = ~valid_q | ks_ready;
    acc_full_s = (bit_cnt_q == 4'd8);
    stall_s    = acc_full_s & valid_q & ~ks_ready;
    step_s     = step_en_q & ~stall_s;
    capture_s  = step_s & (state_q == S_RUN);
    prod_inc_s = prod_q + CNT_W'(1);
    acpt_inc_s = acpt_q + CNT_W'(1);
  end

  assign x_trig   = step_s & (force_s | (x_maj == maj_s));
  assign y_trig   = step_s & (force_s | (y_maj == maj_s));
  assign z_trig   = step_s & (force_s | (z_maj == maj_s));
  assign ld_key   = ld_key_q;
  assign ks_data  = data_q;
  assign ks_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state logic: byte packing, output register, counters and FSM.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    prod_d      = prod_q;
    acpt_d      = acpt_q;
    warm_d      = warm_q;
    step_en_d   = step_en_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    byte_done_s = 1'b0;
    shifted_s   = {acc_q[6:0], bit_s};

    // A handshake empties the output register unless a byte lands below.
    if (hs_s) begin
      valid_d = 1'b0;
      acpt_d  = acpt_inc_s;
    end else begin
      valid_d = valid_q;
      acpt_d  = acpt_q;
    end

    if (acc_full_s && out_free_s) begin
      // Parked byte moves out; a bit captured now starts the next byte.
      data_d  = acc_q;
      valid_d = 1'b1;
      if (capture_s) begin
        acc_d     = {7'd0, bit_s};
        bit_cnt_d = 4'd1;
      end else begin
        acc_d     = 8'd0;
        bit_cnt_d = 4'd0;
      end
    end else if (capture_s) begin
      if (bit_cnt_q == 4'd7) begin
        byte_done_s = 1'b1;
        if (out_free_s) begin
          data_d    = shifted_s;
          valid_d   = 1'b1;
          acc_d     = 8'd0;
          bit_cnt_d = 4'd0;
        end else begin
          acc_d     = shifted_s;
          bit_cnt_d = 4'd8;
        end
      end else begin
        acc_d     = shifted_s;
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      acc_d     = acc_q;
      bit_cnt_d = bit_cnt_q;
    end

    if (byte_done_s) begin
      prod_d = prod_inc_s;
    end else begin
      prod_d = prod_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_bytes != {CNT_W{1'b0}}) begin
            state_d = S_LOAD;
            num_d   = num_bytes;
            prod_d  = {CNT_W{1'b0}};
            acpt_d  = {CNT_W{1'b0}};
            warm_d  = {WARM_W{1'b0}};
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d   = S_WARM;
        step_en_d = 1'b1;
      end
      S_WARM: begin
        if (warm_q == WARM_W'(WARMUP_STEPS - 1)) begin
          state_d = S_RUN;
          warm_d  = {WARM_W{1'b0}};
        end else begin
          warm_d = warm_q + WARM_W'(1);
        end
      end
      S_RUN: begin
        // The last byte is assembled: stop stepping and wait for it to drain.
        if (byte_done_s && (prod_inc_s == num_q)) begin
          state_d   = S_DRAIN;
          step_en_d = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (hs_s && (acpt_inc_s == num_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d   = S_IDLE;
        step_en_d = 1'b0;
      end
    endcase

    // Abort beats everything, including a simultaneous start.
    if (abort) begin
      state_d   = S_IDLE;
      step_en_d = 1'b0;
      acc_d     = 8'd0;
      bit_cnt_d = 4'd0;
      data_d    = 8'd0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
    end else begin
      state_d = state_d;
    end

    ld_key_d = (state_d == S_LOAD);
    busy_d   = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      num_q     <= {CNT_W{1'b0}};
      prod_q    <= {CNT_W{1'b0}};
      acpt_q    <= {CNT_W{1'b0}};
      warm_q    <= {WARM_W{1'b0}};
      step_en_q <= 1'b0;
      acc_q     <= 8'd0;
      bit_cnt_q <= 4'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      ld_key_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      prod_q    <= prod_d;
      acpt_q    <= acpt_d;
      warm_q    <= warm_d;
      step_en_q <= step_en_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ld_key_q  <= ld_key_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_a5_1_keystream_ctrl.sv
// Directed + randomized bench for a5_1_keystream_ctrl. Behavioural X/Y/Z
// registers sit around the DUT; expected keystream bytes come from a
// software A5/1 model (vote-count majority, masked-parity feedback).
`timescale 1ns/1ps
module tb_a5_1_keystream_ctrl;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n, start, abort, ks_ready;
  logic [CNT_W-1:0] num_bytes;
  logic ld_key, x_trig, y_trig, z_trig, ks_valid, busy, done;
  logic x_maj, y_maj, z_maj, x_out, y_out, z_out;
  logic [7:0] ks_data;
`ifdef A51_FORCE_STEP_EN
  logic force_step = 1'b0;
`endif

  a5_1_keystream_ctrl #(.WARMUP_STEPS(100), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_bytes(num_bytes), .abort(abort),
    .ld_key(ld_key), .x_trig(x_trig), .y_trig(y_trig), .z_trig(z_trig),
    .x_maj(x_maj), .y_maj(y_maj), .z_maj(z_maj),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .busy(busy), .done(done)
`ifdef A51_FORCE_STEP_EN
    , .force_step(force_step)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- environment: the three LFSRs or fixed patterns --------
  logic [18:0] rx = 19'd0;
  logic [21:0] ry = 22'd0;
  logic [22:0] rz = 23'd0;
  logic [18:0] kx = 19'd1;
  logic [21:0] ky = 22'd1;
  logic [22:0] kz = 23'd1;
  int unsigned edge_steps = 0;
  bit lfsr_mode = 1'b0;
  bit alt_mode  = 1'b0;
  bit alt_base  = 1'b0;
  logic [2:0] pat_maj = 3'b110;
  logic [2:0] pat_out = 3'b100;
  logic alt_bit;

  // LFSRs latch the key on ld_key and step on their trig.
  always @(posedge clk) begin
    if (ld_key) begin
      rx <= kx; ry <= ky; rz <= kz;
    end else begin
      if (x_trig) rx <= {rx[17:0], rx[18] ^ rx[17] ^ rx[16] ^ rx[13]};
      if (y_trig) ry <= {ry[20:0], ry[21] ^ ry[20]};
      if (z_trig) rz <= {rz[21:0], rz[22] ^ rz[21] ^ rz[20] ^ rz[7]};
    end
    if (x_trig | y_trig | z_trig) edge_steps <= edge_steps + 1;
  end

  assign alt_bit = ~(edge_steps[0] ^ alt_base);
  assign x_maj = lfsr_mode ? rx[8]  : pat_maj[2];
  assign y_maj = lfsr_mode ? ry[10] : pat_maj[1];
  assign z_maj = lfsr_mode ? rz[10] : pat_maj[0];
  assign x_out = lfsr_mode ? rx[18] : (alt_mode ? alt_bit : pat_out[2]);
  assign y_out = lfsr_mode ? ry[21] : pat_out[1];
  assign z_out = lfsr_mode ? rz[22] : pat_out[0];

  // ---------------- monitor (samples on the falling edge) -----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ld_cnt = 0, ld_cyc = -1, done_cnt = 0, done_cyc = -1;
  int step_cnt = 0, xt_cnt = 0, yt_cnt = 0, zt_cnt = 0;
  int first_step_cyc = -1, first_valid_cyc = -1;
  bit pend_step = 1'b0, pend_valid = 1'b0;
  int stab_viol = 0, two_viol = 0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] got_q[$];
  int got_cyc[$];

  always @(negedge clk) begin
    if (ld_key) begin
      ld_cnt <= ld_cnt + 1; ld_cyc <= cyc; pend_step <= 1'b1; pend_valid <= 1'b1;
    end else begin
      if (pend_step && (x_trig | y_trig | z_trig)) begin
        first_step_cyc <= cyc; pend_step <= 1'b0;
      end
      if (pend_valid && ks_valid) begin
        first_valid_cyc <= cyc; pend_valid <= 1'b0;
      end
    end
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (x_trig | y_trig | z_trig) step_cnt <= step_cnt + 1;
    if (x_trig) xt_cnt <= xt_cnt + 1;
    if (y_trig) yt_cnt <= yt_cnt + 1;
    if (z_trig) zt_cnt <= zt_cnt + 1;
    if (({2'b00, x_trig} + {2'b00, y_trig} + {2'b00, z_trig}) == 3'd1) two_viol <= two_viol + 1;
    if (ks_valid && ks_ready) begin
      got_q.push_back(ks_data); got_cyc.push_back(cyc);
    end
    if (prev_hold && rst_n && !(ks_valid && ks_data == prev_data)) stab_viol <= stab_viol + 1;
    prev_hold <= rst_n & ks_valid & ~ks_ready & ~abort;
    prev_data <= ks_data;
  end

  // ---------------- reference model ---------------------------------------
  logic [7:0] exp_q[$];

  function automatic logic [63:0] a51_step(input logic [63:0] s);
    logic [18:0] a; logic [21:0] b; logic [22:0] c; logic m;
    a = s[63:45]; b = s[44:23]; c = s[22:0];
    m = (int'(a[8]) + int'(b[10]) + int'(c[10])) >= 2;
    if (a[8] == m)  a = {a[17:0], ^(a & 19'h72000)};
    if (b[10] == m) b = {b[20:0], ^(b & 22'h300000)};
    if (c[10] == m) c = {c[21:0], ^(c & 23'h700080)};
    return {a, b, c};
  endfunction

  task automatic gen_ref(input int n);
    logic [63:0] s; logic [7:0] v;
    s = {kx, ky, kz};
    exp_q.delete();
    repeat (100) s = a51_step(s);
    for (int i = 0; i < n; i++) begin
      v = 8'd0;
      repeat (8) begin
        v = {v[6:0], s[63] ^ s[44] ^ s[22]};
        s = a51_step(s);
      end
      exp_q.push_back(v);
    end
  endtask

  // ---------------- checking helpers --------------------------------------
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input int n, output int t);
    @(posedge clk); #1;
    start = 1'b1; num_bytes = CNT_W'(n); t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // rmode: 1 = ready high, 2 = random ready each cycle.
  task automatic run_to_done(input int budget, input int rmode);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      ks_ready = (rmode == 1) ? 1'b1 : 1'(($urandom % 2));
      if (done) begin seen = 1'b1; break; end
    end
    chk("done_within_budget", seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic cmp_bytes(input string tag, input int base, input int n);
    chk({tag, "_count"}, got_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < got_q.size()) chk(tag, got_q[base + i], exp_q[i]);
    end
  endtask

  task automatic rand_keys();
    kx = 19'($urandom) | 19'd1;
    ky = 22'($urandom) | 22'd1;
    kz = 23'($urandom) | 23'd1;
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + randomized sequence ------------------------
  initial begin
    int t, b, s0, s1, s2, sx, sy, sz, d0, l0, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ks_ready = 1'b0; num_bytes = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_outs", {ld_key, x_trig, y_trig, z_trig, ks_valid, busy, done, ks_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);

    // num_bytes=1, maj 1/1/0, outs 1/0/0: ld_key timing and warm-up trigs.
    lfsr_mode = 1'b0; pat_maj = 3'b110; pat_out = 3'b100; ks_ready = 1'b1;
    b = got_q.size(); l0 = ld_cnt;
    do_start(1, t);
    wait_cycle_to(t + 2);
    sx = xt_cnt; sy = yt_cnt; sz = zt_cnt;
    wait_cycle_to(t + 102);
    chk("warm_x_trigs", xt_cnt - sx, 100);
    chk("warm_y_trigs", yt_cnt - sy, 100);
    chk("warm_z_trigs", zt_cnt - sz, 0);
    run_to_done(300, 1);
    chk("ld_key_count", ld_cnt - l0, 1);
    chk("ld_key_cycle", ld_cyc - t, 1);
    chk("first_step_cycle", first_step_cyc - t, 2);
    chk("first_valid_cycle", first_valid_cyc - t, 110);
    chk("byte_ff_single", (got_q.size() > b) ? got_q[b] : -1, 8'hFF);
    chk("done_cycle_n1", done_cyc - t, 111);
    chk("busy_after_done", busy, 0);

    // num_bytes=2, ready high: FF at T+110 and T+118, done at T+119.
    b = got_q.size();
    do_start(2, t);
    run_to_done(300, 1);
    exp_q.delete(); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    cmp_bytes("byte_ff_pair", b, 2);
    chk("byte0_cycle", (got_cyc.size() > b) ? got_cyc[b] - t : -1, 110);
    chk("byte1_cycle", (got_cyc.size() > b + 1) ? got_cyc[b + 1] - t : -1, 118);
    chk("done_cycle_n2", done_cyc - t, 119);

    // Outputs alternating 1,0,... per step: 0xAA bytes.
    alt_mode = 1'b1; alt_base = edge_steps[0];
    b = got_q.size();
    do_start(2, t);
    run_to_done(300, 1);
    exp_q.delete(); exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
    cmp_bytes("byte_alt", b, 2);
    alt_mode = 1'b0;

    // Back-pressure from the first byte, num_bytes=3, real LFSR keystream.
    lfsr_mode = 1'b1; rand_keys(); ks_ready = 1'b0;
    b = got_q.size();
    do_start(3, t);
    wait_cycle_to(t + 110);
    s0 = step_cnt;
    wait_cycle_to(t + 118);
    s1 = step_cnt;
    chk("steps_fill_acc", s1 - s0, 8);
    wait_cycle_to(t + 130);
    s2 = step_cnt;
    chk("steps_while_stalled", s2 - s1, 0);
    chk("valid_while_stalled", ks_valid, 1);
    ks_ready = 1'b1;
    run_to_done(300, 1);
    gen_ref(3);
    cmp_bytes("stall_bytes", b, 3);
    chk("stall_byte2_cycle", (got_cyc.size() > b + 2) ? got_cyc[b + 2] - t : -1, 138);
    chk("stall_done_cycle", done_cyc - t, 139);

    // Randomized keys, lengths and ready pattern.
    for (int r = 0; r < 4; r++) begin
      rand_keys();
      n = $urandom_range(1, 5);
      b = got_q.size(); d0 = done_cnt;
      do_start(n, t);
      run_to_done(2000, 2);
      gen_ref(n);
      cmp_bytes("rand_bytes", b, n);
      chk("rand_done_pulses", done_cnt - d0, 1);
    end
    ks_ready = 1'b1;

    // num_bytes=0: done next cycle, no load.
    l0 = ld_cnt;
    do_start(0, t);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(posedge clk); #1;
    chk("zero_done_pulse_len", done, 0);
    chk("zero_no_ld_key", ld_cnt - l0, 0);

    // Abort at T+50: idle at T+51, no done pulse.
    d0 = done_cnt; b = got_q.size();
    do_start(2, t);
    wait_cycle_to(t + 50);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_outs", {busy, x_trig, y_trig, z_trig, ks_valid}, 0);
    repeat (150) @(posedge clk); #1;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_bytes", got_q.size() - b, 0);

    // Start and abort together: abort wins.
    l0 = ld_cnt;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; num_bytes = CNT_W'(1);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    @(posedge clk); #1;
    chk("start_abort_no_ld", ld_cnt - l0, 0);

    // Reset in the middle of RUN, then a clean run from IDLE.
    do_start(4, t);
    wait_cycle_to(t + 105);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outs", {ld_key, x_trig, y_trig, z_trig, ks_valid, busy, done, ks_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", busy, 0);
    rand_keys();
    b = got_q.size();
    do_start(1, t);
    run_to_done(300, 1);
    gen_ref(1);
    cmp_bytes("post_reset_bytes", b, 1);

    chk("two_or_more_trigs", two_viol, 0);
    chk("stable_under_backpressure", stab_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/a5_1_keystream_ctrl.md
Name: a5_1_keystream_ctrl

Overview:
Sequencer for the three A5/1 LFSRs: X is 19-bit, Y is 22-bit, Z is 23-bit, each with load/trigger/out/maj pins. The block:
- issues the key-load strobe;
- runs the warm-up phase with majority clocking, discarding its output;
- generates keystream bits as the XOR of the register MSBs;
- packs the bits into bytes and delivers them over a valid/ready stream to the image-encrypt XOR stage.
Register stepping stalls under back-pressure, so no keystream bit is lost.

Parameters:
WARMUP_STEPS, 100, majority-clocked steps after load whose output is discarded.
CNT_W, 16, width of the byte-count request.

Ports:
clk  in  1  rising-edge clock shared with the X/Y/Z registers
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
num_bytes  in  CNT_W  keystream bytes to produce; sampled with start
abort  in  1  return to IDLE next cycle; pending data is dropped
ld_key  out  1  load strobe to all three registers (they latch the key on this cycle's edge)
x_trig  out  1  step X this cycle
y_trig  out  1  step Y this cycle
z_trig  out  1  step Z this cycle
x_maj  in  1  X clocking bit
y_maj  in  1  Y clocking bit
z_maj  in  1  Z clocking bit
x_out  in  1  X MSB
y_out  in  1  Y MSB
z_out  in  1  Z MSB
ks_data  out  8  keystream byte; first generated bit in ks_data[7]
ks_valid  out  1  ks_data valid
ks_ready  in  1  consumer accepts when ks_valid && ks_ready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset: state IDLE. ld_key, all trig outputs, ks_valid, done, busy, ks_data, the bit accumulator and the counters are all 0. Asynchronous assertion takes effect immediately, including mid-operation. The LFSR contents are not touched.
- Majority m = (x_maj&y_maj)|(x_maj&z_maj)|(y_maj&z_maj). On a step cycle, each trig = (its maj == m), so at least two registers step. trigs are combinational from the maj inputs, gated by a registered step_en.
- States:
  - IDLE: start with num_bytes != 0 → LOAD, latching num_bytes. start with num_bytes == 0 → done pulses the next cycle and the state stays IDLE. start while busy is ignored.
  - LOAD: ld_key = 1 for exactly one cycle, trigs 0 → WARM.
  - WARM: step on every cycle, ks bits discarded. After WARMUP_STEPS cycles → RUN.
  - RUN: on each step cycle, capture b = x_out^y_out^z_out (the state after the previous step) into the accumulator, MSB first.
    - When 8 bits are captured, the byte moves to the ks_data output register if it is empty, or is emptied in the same cycle by a handshake.
    - When both the accumulator (8 bits) and the output register are full and ks_ready = 0, step_en = 0: no trig asserted and no bit captured.
    - When the last requested byte is produced, stepping stops. → DRAIN.
  - DRAIN: wait for the final handshake, then done = 1 for one cycle → IDLE.
- Latency: with start at cycle T:
  - ld_key at T+1;
  - warm-up steps at T+2..T+101;
  - first RUN steps at T+102..T+109;
  - first ks_valid at T+110.
  - With ks_ready held high, one byte every 8 cycles thereafter.
- ks_data and ks_valid are held stable while ks_valid && !ks_ready.
- abort in any state: next cycle IDLE. trigs, ks_valid and the accumulator are cleared. No done pulse.
- abort and start in the same cycle: abort wins.
- The byte counter counts accepted bytes; it does not wrap, since a request is at most 2^CNT_W-1 bytes.

Optional Feature:
A51_FORCE_STEP_EN:
- Defined: adds input force_step (1 bit). While it is high on a step cycle, x_trig, y_trig and z_trig are all 1 (plain LFSR stepping, used for register bring-up and debug). Stall and abort rules are unchanged.
- Undefined: the port is absent and only majority clocking is used.

Test Plan:
- Reset mid-RUN (rst_n low at cycle T+105) → all outputs 0 in the same cycle; after release the block is IDLE and busy = 0.
- start with num_bytes = 1; hold x_maj=1, y_maj=1, z_maj=0 → ld_key only at T+1; x_trig = y_trig = 1 and z_trig = 0 for exactly 100 WARM cycles.
- RUN with x_out=1, y_out=0, z_out=0, ks_ready = 1, num_bytes = 2 → ks_data = 0xFF at T+110 and T+118; done at T+119.
- RUN with outs alternating 1,0 per step (starting with 1) → ks_data = 0xAA.
- ks_ready = 0 from the first byte, num_bytes = 3 → the second byte fills the accumulator at T+117, then all trigs are 0 until ks_ready rises; no bits are lost and the bytes come out in order.
- num_bytes = 0 → done pulse at T+1 with ld_key never asserted. abort at T+50 → IDLE at T+51 with no done pulse.
